// File: rtl/reg_access_arbiter.sv
`timescale 1ns/1ps
// ============================================================================
// reg_access_arbiter
// ----------------------------------------------------------------------------
// Shares a single-port register memory between two requesters, the SPI slave
// and the internal core sequencer. Each access is accepted with a req/gnt
// handshake, issued to the memory for exactly one cycle, and for reads the
// data comes back to the winner with a one-cycle rvalid pulse.
//
// Access timeline, with edge N being the IDLE edge that samples a request:
//   cycle N+1  ISSUE  gnt pulse to the winner, mem_en/we/addr/wdata valid
//   cycle N+2  IDLE   (write)   | RWAIT  mem_rdata captured at its end (read)
//   cycle N+3                   | RRET   rvalid pulse, rdata updated
//   cycle N+4                   | IDLE
//
// Addresses at or above REG_DEPTH are out of range: the access is still
// granted, but mem_en stays low, a write is dropped and a read returns 0.
//
// Build option:
//   REG_ARB_ROUND_ROBIN_EN  defined   -> round-robin between SPI and core,
//                                        a last-winner flop resets to core.
//                           undefined -> fixed SPI priority with a core
//                                        starvation guard (STARVE_LIMIT).
//
// Parameters:
//   ADDR_W        register address width
//   DATA_W        register value width
//   REG_DEPTH     number of implemented registers
//   STARVE_LIMIT  core wait cycles (1..15) after which core beats SPI
//
// Ports:
//   clk, rst_n                      clock (rising edge), async active-low reset
//   spi_req/we/addr/wdata   in      SPI request; fields stable until spi_gnt
//   spi_gnt                 out     one-cycle grant pulse
//   spi_rvalid              out     one-cycle read-data-valid pulse
//   spi_rdata               out     SPI read data, held until the next SPI read
//   core_*                          same set for the core sequencer
//   mem_en/we/addr/wdata    out     memory port, valid for the ISSUE cycle
//   mem_rdata               in      memory read data, one cycle after a read
//   busy                    out     high whenever the FSM is not in IDLE
// ============================================================================
module reg_access_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 12,
    parameter int REG_DEPTH    = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              spi_req,
    input  logic              spi_we,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_gnt,
    output logic              spi_rvalid,
    output logic [DATA_W-1:0] spi_rdata,

    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        RRET  = 2'd3
    } state_t;

    // One extra bit so REG_DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(REG_DEPTH);

    state_t state, state_d;

    // Attributes of the access in flight, latched when it wins in IDLE.
    logic win_core, win_core_d;
    logic op_we,    op_we_d;
    logic op_oor,   op_oor_d;

    // Next-cycle values of the registered outputs.
    logic              spi_gnt_d,    core_gnt_d;
    logic              spi_rvalid_d, core_rvalid_d;
    logic [DATA_W-1:0] spi_rdata_d,  core_rdata_d;
    logic              mem_en_d,     mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    // Request selection: fields of whichever side wins this IDLE edge.
    logic              any_req;
    logic              core_pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_oor;

    assign any_req   = spi_req | core_req;
    assign sel_we    = core_pick ? core_we    : spi_we;
    assign sel_addr  = core_pick ? core_addr  : spi_addr;
    assign sel_wdata = core_pick ? core_wdata : spi_wdata;
    assign sel_oor   = ({1'b0, sel_addr} >= DEPTH_LIM);

`ifdef REG_ARB_ROUND_ROBIN_EN
    // ------------------------------------------------------------------
    // Round-robin: on a tie the side that did not win last time goes.
    // last_core resets to 1 so the first tie after reset goes to SPI.
    // ------------------------------------------------------------------
    logic last_core;

    assign core_pick = core_req & (~spi_req | ~last_core);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_core <= 1'b1;
        end else if (state == IDLE && any_req) begin
            last_core <= core_pick;
        end
    end
`else
    // ------------------------------------------------------------------
    // Fixed SPI priority with a starvation guard. starve_cnt counts the
    // cycles the core has been requesting without a grant pulse; once it
    // reaches STARVE_LIMIT the core wins the next tie.
    // ------------------------------------------------------------------
    logic [3:0] starve_cnt;
    logic       starved;

    assign starved   = (starve_cnt >= 4'(STARVE_LIMIT));
    assign core_pick = core_req & (~spi_req | starved);

    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples the pre-edge values and the simulation matches the hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (!core_req || core_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d       = state;
        win_core_d    = win_core;
        op_we_d       = op_we;
        op_oor_d      = op_oor;
        spi_gnt_d     = 1'b0;
        core_gnt_d    = 1'b0;
        spi_rvalid_d  = 1'b0;
        core_rvalid_d = 1'b0;
        spi_rdata_d   = spi_rdata;
        core_rdata_d  = core_rdata;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = '0;
        mem_wdata_d   = '0;

        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_d    = ISSUE;
                    win_core_d = core_pick;
                    op_we_d    = sel_we;
                    op_oor_d   = sel_oor;
                    spi_gnt_d  = ~core_pick;
                    core_gnt_d = core_pick;
                    // Out-of-range accesses are granted but never reach memory.
                    mem_en_d   = ~sel_oor;
                    mem_we_d   = sel_we & ~sel_oor;
                    mem_addr_d = sel_addr;
                    mem_wdata_d = sel_we ? sel_wdata : '0;
                end
            end

            ISSUE: begin
                state_d = op_we ? IDLE : RWAIT;
            end

            RWAIT: begin
                // Memory data is valid during this cycle; capture it into
                // the winner's rdata register so it appears in RRET.
                state_d = RRET;
                if (win_core) begin
                    core_rvalid_d = 1'b1;
                    core_rdata_d  = op_oor ? '0 : mem_rdata;
                end else begin
                    spi_rvalid_d  = 1'b1;
                    spi_rdata_d   = op_oor ? '0 : mem_rdata;
                end
            end

            RRET: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. An async reset aborts any access in
    // flight: no pending grant or rvalid survives it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            win_core    <= 1'b0;
            op_we       <= 1'b0;
            op_oor      <= 1'b0;
            spi_gnt     <= 1'b0;
            core_gnt    <= 1'b0;
            spi_rvalid  <= 1'b0;
            core_rvalid <= 1'b0;
            spi_rdata   <= '0;
            core_rdata  <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state       <= state_d;
            win_core    <= win_core_d;
            op_we       <= op_we_d;
            op_oor      <= op_oor_d;
            spi_gnt     <= spi_gnt_d;
            core_gnt    <= core_gnt_d;
            spi_rvalid  <= spi_rvalid_d;
            core_rvalid <= core_rvalid_d;
            spi_rdata   <= spi_rdata_d;
            core_rdata  <= core_rdata_d;
            mem_en      <= mem_en_d;
            mem_we      <= mem_we_d;
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_reg_access_arbiter.sv
`timescale 1ns/1ps
// ============================================================================
// tb_reg_access_arbiter
// ----------------------------------------------------------------------------
// Directed bench for reg_access_arbiter. A small behavioural memory sits on
// the mem_* port (read data one cycle after mem_en & ~mem_we). Inputs are
// driven 1 ns after the rising edge and outputs are sampled at the same
// point, so every sample sees the state left by the preceding edge.
// ADDR_W is 9 so that 0x1FF is an out-of-range address for REG_DEPTH = 256.
// ============================================================================
module tb_reg_access_arbiter;

    localparam int AW = 9;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_req = 1'b0, spi_we = 1'b0;
    logic [AW-1:0] spi_addr = '0;
    logic [DW-1:0] spi_wdata = '0;
    logic          spi_gnt, spi_rvalid;
    logic [DW-1:0] spi_rdata;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_gnt, core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          mem_init = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [51:0] outs;
    assign outs = {spi_gnt, spi_rvalid, spi_rdata, core_gnt, core_rvalid, core_rdata,
                   mem_en, mem_we, mem_addr, mem_wdata, busy};

`ifdef REG_ARB_ROUND_ROBIN_EN
    localparam logic CF = 1'b1;   // core wins the tie in test_priority
`else
    localparam logic CF = 1'b0;
`endif

    reg_access_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .REG_DEPTH(256), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_gnt(spi_gnt), .spi_rvalid(spi_rvalid), .spi_rdata(spi_rdata),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural 256x12 register memory with preset contents.
    logic [DW-1:0] mem_model [256];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= '0;
            mem_model[8'h10] <= 12'h111;
            mem_model[8'h11] <= 12'h222;
            mem_model[8'h31] <= 12'h0AB;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem_model[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= mem_model[mem_addr[7:0]];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0;
        mem_init = 1'b1;
        tick; tick;
        checks++; if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h want 0", outs); end
`ifndef REG_ARB_ROUND_ROBIN_EN
        checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt); end
`endif
        mem_init = 1'b0;
        rst_n = 1'b1;
        tick;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_write_read;
        spi_we = 1'b1; spi_addr = 9'h02A; spi_wdata = 12'd1234; spi_req = 1'b1;
        tick;   // edge N sampled the request
        checks++; if (spi_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", spi_gnt); end
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'h02A, 12'd1234})
            begin errors++; $display("FAIL wr_mem_port: got en=%b we=%b a=%h d=%0d want en=1 we=1 a=02a d=1234", mem_en, mem_we, mem_addr, mem_wdata); end
        checks++; if (core_gnt !== 1'b0) begin errors++; $display("FAIL wr_core_gnt: got %b want 0", core_gnt); end
        spi_req = 1'b0;
        tick;
        checks++; if ({spi_gnt, mem_en, busy} !== 3'b000) begin errors++; $display("FAIL wr_done: got gnt/en/busy=%b want 000", {spi_gnt, mem_en, busy}); end

        spi_we = 1'b0; spi_req = 1'b1;
        tick;
        checks++; if ({spi_gnt, mem_en, mem_we} !== 3'b110) begin errors++; $display("FAIL rd_gnt: got gnt/en/we=%b want 110", {spi_gnt, mem_en, mem_we}); end
        spi_req = 1'b0;
        tick;   // RWAIT
        checks++; if ({spi_rvalid, busy} !== 2'b01) begin errors++; $display("FAIL rd_rwait: got rvalid/busy=%b want 01", {spi_rvalid, busy}); end
        tick;   // RRET
        checks++; if (spi_rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", spi_rvalid); end
        checks++; if (spi_rdata !== 12'd1234) begin errors++; $display("FAIL rd_data: got %0d want 1234", spi_rdata); end
        tick;   // IDLE
        checks++; if ({spi_rvalid, busy} !== 2'b00) begin errors++; $display("FAIL rd_end: got rvalid/busy=%b want 00", {spi_rvalid, busy}); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_priority;
        spi_we = 1'b0;  spi_addr = 9'h010;  spi_req = 1'b1;
        core_we = 1'b0; core_addr = 9'h011; core_req = 1'b1;
        tick;   // edge N
        checks++; if ({spi_gnt, core_gnt} !== {~CF, CF}) begin errors++; $display("FAIL prio_first: got spi/core gnt=%b want %b", {spi_gnt, core_gnt}, {~CF, CF}); end
        if (CF) core_req = 1'b0; else spi_req = 1'b0;
        tick; tick;   // RRET of the first access
        checks++; if ({spi_rvalid, core_rvalid} !== {~CF, CF}) begin errors++; $display("FAIL prio_rvalid1: got %b want %b", {spi_rvalid, core_rvalid}, {~CF, CF}); end
        checks++; if ((CF ? core_rdata : spi_rdata) !== (CF ? 12'h222 : 12'h111)) begin errors++; $display("FAIL prio_data1: got spi=%h core=%h", spi_rdata, core_rdata); end
        tick;   // N+3, back in IDLE, no grant yet
        checks++; if ({spi_gnt, core_gnt} !== 2'b00) begin errors++; $display("FAIL prio_gap: got %b want 00", {spi_gnt, core_gnt}); end
        tick;   // N+4, second grant
        checks++; if ({spi_gnt, core_gnt} !== {CF, ~CF}) begin errors++; $display("FAIL prio_second: got spi/core gnt=%b want %b", {spi_gnt, core_gnt}, {CF, ~CF}); end
        spi_req = 1'b0; core_req = 1'b0;
        tick; tick;
        checks++; if ({spi_rvalid, core_rvalid} !== {CF, ~CF}) begin errors++; $display("FAIL prio_rvalid2: got %b want %b", {spi_rvalid, core_rvalid}, {CF, ~CF}); end
        checks++; if ((CF ? spi_rdata : core_rdata) !== (CF ? 12'h111 : 12'h222)) begin errors++; $display("FAIL prio_data2: got spi=%h core=%h", spi_rdata, core_rdata); end
        tick;
    endtask

    // ------------------------------------------------------------------
`ifndef REG_ARB_ROUND_ROBIN_EN
    task automatic test_starvation;
        spi_we = 1'b1;  spi_addr = 9'h030;  spi_wdata = 12'd1; spi_req = 1'b1;
        core_we = 1'b0; core_addr = 9'h031; core_req = 1'b1;
        tick;   // E0: SPI write 1
        checks++; if ({spi_gnt, core_gnt, mem_wdata} !== {2'b10, 12'd1}) begin errors++; $display("FAIL starve_w1: got gnt=%b d=%0d want 10 d=1", {spi_gnt, core_gnt}, mem_wdata); end
        checks++; if (dut.starve_cnt !== 4'd1) begin errors++; $display("FAIL starve_cnt1: got %0d want 1", dut.starve_cnt); end
        spi_wdata = 12'd2;
        tick;   // E1
        checks++; if (dut.starve_cnt !== 4'd2) begin errors++; $display("FAIL starve_cnt2: got %0d want 2", dut.starve_cnt); end
        tick;   // E2: SPI write 2
        checks++; if ({spi_gnt, core_gnt, mem_wdata} !== {2'b10, 12'd2}) begin errors++; $display("FAIL starve_w2: got gnt=%b d=%0d want 10 d=2", {spi_gnt, core_gnt}, mem_wdata); end
        spi_wdata = 12'd3;
        tick;   // E3
        checks++; if (dut.starve_cnt !== 4'd4) begin errors++; $display("FAIL starve_cnt4: got %0d want 4", dut.starve_cnt); end
        tick;   // E4: core beats SPI
        checks++; if ({spi_gnt, core_gnt, mem_addr} !== {2'b01, 9'h031}) begin errors++; $display("FAIL starve_core_gnt: got gnt=%b a=%h want 01 a=031", {spi_gnt, core_gnt}, mem_addr); end
        core_req = 1'b0;
        tick;   // E5
        checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt); end
        tick;   // E6: core RRET
        checks++; if ({core_rvalid, core_rdata} !== {1'b1, 12'h0AB}) begin errors++; $display("FAIL starve_core_rd: got v=%b d=%h want v=1 d=0ab", core_rvalid, core_rdata); end
        tick; tick;   // E8: pending SPI write 3 granted
        checks++; if ({spi_gnt, mem_wdata} !== {1'b1, 12'd3}) begin errors++; $display("FAIL starve_w3: got gnt=%b d=%0d want gnt=1 d=3", spi_gnt, mem_wdata); end
        spi_req = 1'b0;
        tick;
    endtask
`endif

    // ------------------------------------------------------------------
    task automatic test_out_of_range;
        core_we = 1'b1; core_addr = 9'h1FF; core_wdata = 12'h555; core_req = 1'b1;
        tick;
        checks++; if ({core_gnt, mem_en, mem_we} !== 3'b100) begin errors++; $display("FAIL oor_wr: got gnt/en/we=%b want 100", {core_gnt, mem_en, mem_we}); end
        core_req = 1'b0;
        tick;
        checks++; if ({mem_en, busy} !== 2'b00) begin errors++; $display("FAIL oor_wr_done: got en/busy=%b want 00", {mem_en, busy}); end
        core_we = 1'b0; core_req = 1'b1;
        tick;
        checks++; if ({core_gnt, mem_en} !== 2'b10) begin errors++; $display("FAIL oor_rd: got gnt/en=%b want 10", {core_gnt, mem_en}); end
        core_req = 1'b0;
        tick; tick;
        checks++; if ({core_rvalid, core_rdata} !== {1'b1, 12'h000}) begin errors++; $display("FAIL oor_rd_data: got v=%b d=%h want v=1 d=000", core_rvalid, core_rdata); end
        tick;
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back;
        core_we = 1'b1; core_addr = 9'h005; core_wdata = 12'd77; core_req = 1'b1;
        tick;   // E0: core write granted
        checks++; if ({core_gnt, mem_en, mem_we, mem_wdata} !== {3'b111, 12'd77}) begin errors++; $display("FAIL b2b_wr: got gnt=%b en=%b we=%b d=%0d", core_gnt, mem_en, mem_we, mem_wdata); end
        core_req = 1'b0;
        spi_we = 1'b0; spi_addr = 9'h005; spi_req = 1'b1;
        tick;   // E1: still ISSUE, no arbitration
        checks++; if (spi_gnt !== 1'b0) begin errors++; $display("FAIL b2b_wait: got %b want 0", spi_gnt); end
        tick;   // E2
        checks++; if (spi_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt: got %b want 1", spi_gnt); end
        spi_req = 1'b0;
        tick; tick;
        checks++; if ({spi_rvalid, spi_rdata} !== {1'b1, 12'd77}) begin errors++; $display("FAIL b2b_data: got v=%b d=%0d want v=1 d=77", spi_rvalid, spi_rdata); end
        tick;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid;
        core_we = 1'b0; core_addr = 9'h010; core_req = 1'b1;
        tick;
        checks++; if (core_gnt !== 1'b1) begin errors++; $display("FAIL rstmid_gnt: got %b want 1", core_gnt); end
        core_req = 1'b0;
        tick;   // RWAIT
        rst_n = 1'b0;
        #1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL rstmid_outs: got %h want 0", outs); end
        tick;
        checks++; if (core_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid: got %b want 0", core_rvalid); end
        tick;
        rst_n = 1'b1;
        checks++; if (outs !== '0) begin errors++; $display("FAIL rstmid_outs2: got %h want 0", outs); end
        spi_we = 1'b0; spi_addr = 9'h02A; spi_req = 1'b1;
        tick;
        checks++; if ({spi_gnt, core_gnt} !== 2'b10) begin errors++; $display("FAIL rstmid_spi_gnt: got %b want 10", {spi_gnt, core_gnt}); end
        spi_req = 1'b0;
        tick; tick;
        checks++; if ({spi_rvalid, spi_rdata} !== {1'b1, 12'd1234}) begin errors++; $display("FAIL rstmid_spi_rd: got v=%b d=%0d want v=1 d=1234", spi_rvalid, spi_rdata); end
        tick;
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_priority;
`ifndef REG_ARB_ROUND_ROBIN_EN
        test_starvation;
`endif
        test_out_of_range;
        test_back_to_back;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
